// File: rtl/vend_pkg.sv
// Shared encodings for the vending dispense path: change codes, fault codes, FSM states.
package vend_pkg;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_25   = 2'b01;
  localparam logic [1:0] C_50   = 2'b10;
  localparam logic [1:0] C_BAD  = 2'b11;

  localparam logic [1:0] F_OK           = 2'b00;
  localparam logic [1:0] F_MOTOR_TMO    = 2'b01;
  localparam logic [1:0] F_COIN_TMO     = 2'b10;
  localparam logic [1:0] F_HOPPER_SHORT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_KICK,
    S_WAIT,
    S_FAULT
  } state_t;

  // Number of 25p coins owed for a change code; the invalid code owes nothing.
  function automatic logic [1:0] owed_for(input logic [1:0] code);
    case (code)
      C_25:    return 2'd1;
      C_50:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_tmo_cnt.sv
// Loadable down-counter with a zero flag; shared by the motor, kick and coin timers.
module vend_tmo_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Drives the product motor and coin hopper from one-cycle vend results, tracks
// hopper inventory and reports faults. All outputs are registered.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_TMO = 1000,
  parameter int KICK_W    = 4,
  parameter int COIN_TMO  = 200,
  parameter int COIN_INIT = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             product_req,
  input  logic [1:0]       change_req,
  input  logic             motor_home,
  input  logic             coin_seen,
  input  logic             coin_load,
  output logic             vend_motor,
  output logic             coin_kick,
  output logic             busy,
  output logic             req_dropped,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] coins_left
);

  localparam int TMAX = (MOTOR_TMO > COIN_TMO) ?
                        ((MOTOR_TMO > KICK_W) ? MOTOR_TMO : KICK_W) :
                        ((COIN_TMO > KICK_W) ? COIN_TMO : KICK_W);
  localparam int TW = $clog2(TMAX + 1);
  // Timer reload values are one less than the span: the zero cycle is the last one.
  localparam logic [TW-1:0] MOTOR_LD = TW'(MOTOR_TMO - 1);
  localparam logic [TW-1:0] KICK_LD  = TW'(KICK_W - 1);
  localparam logic [TW-1:0] COIN_LD  = TW'(COIN_TMO - 1);

  state_t           state, state_n;
  logic [1:0]       owed, owed_n, owed_req, fcode_n;
  logic [CNT_W-1:0] coins_n;
  logic             req_any, coin_hit, tmr_load, tmr_zero;
  logic [TW-1:0]    tmr_val;

  assign owed_req = owed_for(change_req);
  assign req_any  = product_req | (change_req == C_25) | (change_req == C_50);
  assign coin_hit = coin_seen & ((state == S_KICK) | (state == S_WAIT));

  vend_tmo_cnt #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_n  = state;
    owed_n   = owed;
    fcode_n  = fault_code;
    coins_n  = coins_left;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (coin_hit && coins_left != '0) coins_n = coins_left - CNT_W'(1);
    case (state)
      S_IDLE: begin
        if (req_any) begin
          owed_n = owed_req;
          if (CNT_W'(owed_req) > coins_left) begin
            fcode_n = F_HOPPER_SHORT;
            owed_n  = 2'd0;
          end
          if (product_req) begin
            state_n  = S_MOTOR;
            tmr_load = 1'b1;
            tmr_val  = MOTOR_LD;
          end else if (owed_n != 2'd0) begin
            state_n  = S_KICK;
            tmr_load = 1'b1;
            tmr_val  = KICK_LD;
          end
        end
      end
      S_MOTOR: begin
        if (motor_home) begin
          if (owed != 2'd0) begin
            state_n  = S_KICK;
            tmr_load = 1'b1;
            tmr_val  = KICK_LD;
          end else begin
            state_n = S_IDLE;
          end
        end else if (tmr_zero) begin
          state_n = S_FAULT;
          fcode_n = F_MOTOR_TMO;
        end
      end
      S_KICK, S_WAIT: begin
        // A coin seen mid-kick counts just like one seen while waiting.
        if (coin_seen) begin
          owed_n = owed - 2'd1;
          if (owed > 2'd1) begin
            state_n  = S_KICK;
            tmr_load = 1'b1;
            tmr_val  = KICK_LD;
          end else begin
            state_n = S_IDLE;
          end
        end else if (tmr_zero) begin
          if (state == S_KICK) begin
            state_n  = S_WAIT;
            tmr_load = 1'b1;
            tmr_val  = COIN_LD;
          end else begin
            state_n = S_FAULT;
            fcode_n = F_COIN_TMO;
          end
        end
      end
      S_FAULT: ;
      default: state_n = S_IDLE;
    endcase
    // A refill overrides any same-cycle coin count and clears a hopper-short report.
    if (coin_load) begin
      coins_n = CNT_W'(COIN_INIT);
      if (fcode_n == F_HOPPER_SHORT) fcode_n = F_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owed        <= 2'd0;
      fault_code  <= F_OK;
      fault       <= 1'b0;
      coins_left  <= CNT_W'(COIN_INIT);
      vend_motor  <= 1'b0;
      coin_kick   <= 1'b0;
      busy        <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      state       <= state_n;
      owed        <= owed_n;
      fault_code  <= fcode_n;
      fault       <= (fcode_n != F_OK);
      coins_left  <= coins_n;
      vend_motor  <= (state_n == S_MOTOR);
      coin_kick   <= (state_n == S_KICK);
      busy        <= (state_n != S_IDLE);
      req_dropped <= req_any & (state != S_IDLE);
    end
  end

endmodule
